// File: rtl/icache_direct.sv
// icache_direct: direct-mapped read-only instruction cache with one-word frames,
// single-word fill over the iREN/iwait handshake and saturating hit/miss counters.
module icache_direct #(
  parameter int NFRAMES = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int IDX_W = $clog2(NFRAMES);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state_q, state_d;
  logic [31:0]        fill_addr_q, fill_addr_d;
  logic [NFRAMES-1:0] valid_q, valid_d;
  logic [31:0]        hit_count_q, hit_count_d;
  logic [31:0]        miss_count_q, miss_count_d;
  logic [TAG_W-1:0]   tag_q [NFRAMES];
  logic [31:0]        data_q [NFRAMES];

  logic [IDX_W-1:0] idx, fidx;
  logic [TAG_W-1:0] tag, ftag;
  logic             miss, fill_done;

  always_comb begin
    idx          = imemaddr[IDX_W+1:2];
    tag          = imemaddr[31:IDX_W+2];
    fidx         = fill_addr_q[IDX_W+1:2];
    ftag         = fill_addr_q[31:IDX_W+2];
    ihit         = (state_q == IDLE) && imemREN && valid_q[idx] && (tag_q[idx] == tag);
    imemload     = ihit ? data_q[idx] : '0;
    iREN         = (state_q == FILL);
    iaddr        = iREN ? fill_addr_q : '0;
    fill_done    = iREN && !iwait;
    miss         = (state_q == IDLE) && imemREN && !ihit;
    state_d      = miss ? FILL : fill_done ? IDLE : state_q;
    fill_addr_d  = miss ? {imemaddr[31:2], 2'b00} : fill_addr_q;
    valid_d      = valid_q;
    if (fill_done) valid_d[fidx] = 1'b1;
    hit_count_d  = (ihit && hit_count_q != '1) ? hit_count_q + 32'd1 : hit_count_q;
    miss_count_d = (miss && miss_count_q != '1) ? miss_count_q + 32'd1 : miss_count_q;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      fill_addr_q  <= '0;
      valid_q      <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      fill_addr_q  <= fill_addr_d;
      valid_q      <= valid_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Tag/data contents are meaningless until the matching valid bit is set, so no reset.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_q[fidx]  <= ftag;
      data_q[fidx] <= iload;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed checks of hit/miss, fill handshake, conflicts and reset.
module tb_icache_direct;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  int          checks = 0;
  int          failures = 0;

  icache_direct dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic fill(input logic [31:0] addr, input logic [31:0] exp_iaddr, input logic [31:0] data);
    imemREN = 1'b1; imemaddr = addr; iwait = 1'b1;
    #1 chk("miss_ihit", {31'd0, ihit}, 32'd0);
    tick();
    iwait = 1'b0; iload = data;
    #1 chk("fill_iren", {31'd0, iREN}, 32'd1);
    chk("fill_iaddr", iaddr, exp_iaddr);
    tick();
    iwait = 1'b1;
  endtask

  initial begin
    nRST = 1'b1; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0;
    #3 nRST = 1'b0;
    #1;
    chk("rst_ihit", {31'd0, ihit}, 32'd0);
    chk("rst_iren", {31'd0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_imemload", imemload, 32'd0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    // first miss with three busy cycles from memory
    imemREN = 1'b1; imemaddr = 32'h40;
    #1 chk("m1_ihit", {31'd0, ihit}, 32'd0);
    chk("m1_iren_idle", {31'd0, iREN}, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      iwait = (i < 3); iload = 32'h2001_0005;
      #1 chk("m1_iren", {31'd0, iREN}, 32'd1);
      chk("m1_iaddr", iaddr, 32'h40);
      chk("m1_nohit", {31'd0, ihit}, 32'd0);
      tick();
    end
    iwait = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("h1_ihit", {31'd0, ihit}, 32'd1);
      chk("h1_load", imemload, 32'h2001_0005);
      chk("h1_iren", {31'd0, iREN}, 32'd0);
      tick();
    end
    chk("h1_hits", hit_count, 32'd5);
    chk("h1_misses", miss_count, 32'd1);
    imemREN = 1'b0;
    #1 chk("noreq_ihit", {31'd0, ihit}, 32'd0);
    chk("noreq_load", imemload, 32'd0);
    tick();
    chk("noreq_hits", hit_count, 32'd5);
    // conflict on index 0
    fill(32'h440, 32'h440, 32'hDEAD_BEEF);
    #1 chk("c_hit440", {31'd0, ihit}, 32'd1);
    chk("c_load440", imemload, 32'hDEAD_BEEF);
    tick();
    imemaddr = 32'h40;
    #1 chk("c_evicted", {31'd0, ihit}, 32'd0);
    tick();
    chk("c_iaddr40", iaddr, 32'h40);
    iwait = 1'b0; iload = 32'h2001_0005;
    tick();
    iwait = 1'b1;
    #1 chk("c_hit40", imemload, 32'h2001_0005);
    tick();
    // byte offset within a word
    fill(32'h47, 32'h44, 32'h1111_2222);
    imemaddr = 32'h44;
    #1 chk("b_ihit", {31'd0, ihit}, 32'd1);
    chk("b_load", imemload, 32'h1111_2222);
    tick();
    // address change while the fill is outstanding
    imemaddr = 32'h80;
    tick();
    imemaddr = 32'h84;
    #1 chk("mf_iaddr_a", iaddr, 32'h80);
    tick();
    iwait = 1'b0; iload = 32'h8080_8080;
    #1 chk("mf_iaddr_b", iaddr, 32'h80);
    tick();
    iwait = 1'b1;
    #1 chk("mf_miss84", {31'd0, ihit}, 32'd0);
    tick();
    chk("mf_iaddr84", iaddr, 32'h84);
    iwait = 1'b0; iload = 32'h8484_8484;
    tick();
    iwait = 1'b1;
    #1 chk("mf_hit84", imemload, 32'h8484_8484);
    tick();
    imemaddr = 32'h80;
    #1 chk("mf_hit80", imemload, 32'h8080_8080);
    tick();
    chk("misses_total", miss_count, 32'd6);
    // reset during a fill
    fill(32'h40, 32'h40, 32'h2001_0005);
    #1 chk("r_hit40", {31'd0, ihit}, 32'd1);
    tick();
    imemaddr = 32'h440;
    tick();
    #1 chk("r_iren_fill", {31'd0, iREN}, 32'd1);
    nRST = 1'b0;
    #1 chk("r_iren_drop", {31'd0, iREN}, 32'd0);
    chk("r_misses", miss_count, 32'd0);
    chk("r_hits", hit_count, 32'd0);
    tick();
    nRST = 1'b1;
    imemaddr = 32'h40;
    #1 chk("r_cold40", {31'd0, ihit}, 32'd0);
    tick();
    chk("r_refill_iren", {31'd0, iREN}, 32'd1);
    chk("r_refill_iaddr", iaddr, 32'h40);
    chk("r_miss1", miss_count, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the pipeline fetch stage and the memory controller.
- Serves imemaddr/imemREN from the datapath. Returns imemload with a single-cycle ihit on a hit.
- On a miss, fetches one word from memory through the iREN/iwait handshake and fills the frame.
- Exposes hit/miss counters for performance runs.

Parameters:
- NFRAMES, 16, number of one-word frames; power of two, at least 2.
- IDX_W, $clog2(NFRAMES), index width; derived, not overridden.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- imemREN  input  1  fetch request from the datapath.
- imemaddr  input  32  fetch byte address; bits [1:0] ignored.
- ihit  output  1  imemload valid this cycle.
- imemload  output  32  instruction word.
- iREN  output  1  read request to the memory controller.
- iaddr  output  32  word-aligned fill address to memory.
- iwait  input  1  high while the memory controller is busy; low = iload valid this cycle.
- iload  input  32  fill data from memory.
- hit_count  output  32  saturating count of cycles with ihit=1.
- miss_count  output  32  saturating count of misses (entries into FILL).

Behaviour:
- Reset is asynchronous on nRST low and is the only action while nRST is low:
  - all valid bits = 0; state = IDLE; hit_count = 0; miss_count = 0.
  - ihit = 0, iREN = 0, iaddr = 0, imemload = 0.
  - Tag/data arrays need no reset.
- Address split: index = imemaddr[IDX_W+1:2]; tag = imemaddr[31:IDX_W+2].
- States: IDLE, FILL.
- IDLE:
  - ihit = imemREN AND valid[index] AND (tagarr[index] == tag); purely combinational, same cycle.
  - imemload = dataarr[index] when ihit=1, else 0.
  - iREN = 0.
  - On imemREN=1 and no hit: latch fill_addr = {imemaddr[31:2], 2'b00}, miss_count++ (saturating), next state = FILL.
  - imemREN=0: no hit, no state change.
- FILL:
  - iREN = 1; iaddr = fill_addr (held stable for the whole fill); ihit = 0; imemload = 0.
  - If iwait=1: remain in FILL.
  - If iwait=0: on that clock edge write the frame: dataarr = iload, tagarr = fill_addr tag, valid = 1. Next state = IDLE.
- Latency:
  - Hit: 0 cycles (ihit in the request cycle).
  - Miss: iwait first low in FILL cycle N, ihit in cycle N+1 provided imemaddr is unchanged.
- Address change during FILL: the fill completes for the latched fill_addr; the new address is looked up in IDLE afterward. No abort.
- imemREN dropped during FILL: the fill still completes.
- Conflict: two addresses with the same index evict each other. A newly filled frame overwrites the tag unconditionally.
- Counters:
  - hit_count increments on every rising edge with ihit=1.
  - Both counters saturate at 32'hFFFFFFFF; no wrap.
- No writes from the datapath. Self-modifying code is unsupported; a flush occurs only via reset.
- Reset mid-FILL: return to IDLE immediately, drop iREN, discard the fill.

Test Plan:
- Reset, then imemREN=1, imemaddr=0x0000_0040, memory iwait high for 3 cycles then low with iload=0x2001_0005:
  - iREN=1 and iaddr=0x40 for 4 cycles.
  - Next cycle ihit=1, imemload=0x2001_0005.
  - miss_count=1.
- Same address 0x40 requested again for 5 cycles -> ihit=1 every cycle, iREN=0, hit_count=5, miss_count unchanged.
- Conflict: fill 0x40, then request 0x440 (same index 0 for NFRAMES=16):
  - Miss, fill with 0xDEAD_BEEF.
  - Re-request 0x40 -> miss again, iaddr=0x40.
- Address 0x44 with byte offset 0x47: same frame as 0x44; second access with 0x44 hits; iaddr=0x44 (low bits cleared).
- Mid-fill address change: miss on 0x80, switch imemaddr to 0x84 while iwait=1:
  - iaddr stays 0x80; frame for 0x80 filled.
  - Then a miss on 0x84 starts a new fill.
- nRST low during FILL with iREN=1 -> iREN=0 immediately; after release, previously cached 0x40 misses (valid cleared).
